// File: rtl/mmio_responder.sv
// Memory-mapped register target: LED, scratch, timer and status in a 4-word window with wait states.
// Optional timer/status logic is built only when MMIO_TIMER_EN is defined.
module mmio_responder #(
  parameter logic [12:0] BASE_ADDR   = 13'h1FF0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [12:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        wr_done,
  output logic        rd_done,
  output logic [3:0]  led
);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StRelease} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdat_q, wdat_d;
  logic [3:0]  led_q;
  logic [15:0] scratch_q;
  logic [15:0] rd_mux;
  logic        sel, req_live, acc_wr, acc_rd;

  assign sel      = (addr[12:2] == BASE_ADDR[12:2]);
  // The latched op decides which request line must stay high during the wait.
  assign req_live = op_wr_q ? write : read;
  assign acc_wr   = (state_q == StAccess) && op_wr_q;
  assign acc_rd   = (state_q == StAccess) && !op_wr_q;
  assign led      = led_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    off_d   = off_q;
    wdat_d  = wdat_q;
    unique case (state_q)
      StIdle: begin
        if (sel && (read || write)) begin
          op_wr_d = write;
          off_d   = addr[1:0];
          wdat_d  = wr_data;
          cnt_d   = WaitInit;
          state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (!req_live) begin
          state_d = StIdle;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess:  state_d = StRelease;
      StRelease: if (!read && !write) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      off_q   <= 2'd0;
      wdat_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [15:0] timer_q;
  logic        status_q;
  logic        timer_wr, status_w1c, ovf;

  assign timer_wr   = acc_wr && (off_q == 2'd2);
  assign status_w1c = acc_wr && (off_q == 2'd3) && wdat_q[0];
  // A CPU load replaces the increment, so a load never reports overflow.
  assign ovf        = !timer_wr && (timer_q == 16'hFFFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q  <= 16'h0;
      status_q <= 1'b0;
    end else begin
      timer_q  <= timer_wr ? wdat_q : timer_q + 16'd1;
      status_q <= (status_q && !status_w1c) || ovf;
    end
  end
`endif

  always_comb begin
    rd_mux = 16'h0;
    unique case (off_q)
      2'd0: rd_mux = {12'h0, led_q};
      2'd1: rd_mux = scratch_q;
`ifdef MMIO_TIMER_EN
      2'd2: rd_mux = timer_q;
      2'd3: rd_mux = {15'h0, status_q};
`else
      2'd2: rd_mux = 16'h0;
      2'd3: rd_mux = 16'h0;
`endif
      default: rd_mux = 16'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data   <= 16'h0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      led_q     <= 4'h0;
      scratch_q <= 16'h0;
    end else begin
      wr_done <= acc_wr;
      rd_done <= acc_rd;
      if (acc_rd) rd_data <= rd_mux;
      if (acc_wr && (off_q == 2'd0)) led_q <= wdat_q[3:0];
      if (acc_wr && (off_q == 2'd1)) scratch_q <= wdat_q;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed steps plus random LED/scratch traffic
// against a register-level model; timer checks follow MMIO_TIMER_EN.
module tb_mmio_responder;
  localparam logic [12:0] BASE = 13'h1FF0;
  localparam int W2 = 2;
  localparam int W4 = 4;
  localparam int KGAP = 30;

  logic        clk = 1'b0, rst = 1'b1;
  logic        read = 1'b0, write = 1'b0, read4 = 1'b0, write4 = 1'b0;
  logic [12:0] addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data, rd_data4;
  logic        wr_done, rd_done, wr_done4, rd_done4;
  logic [3:0]  led, led4;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [3:0]  led_m;
  logic [15:0] scr_m;

  mmio_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(W2)) u_dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .wr_done(wr_done), .rd_done(rd_done), .led(led)
  );

  mmio_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(W4)) u_dut4 (
    .clk(clk), .rst(rst), .read(read4), .write(write4), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data4), .wr_done(wr_done4), .rd_done(rd_done4), .led(led4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic logic [15:0] model_rd(input logic [1:0] off);
    case (off)
      2'd0:    return {12'h0, led_m};
      2'd1:    return scr_m;
      default: return 16'h0;
    endcase
  endfunction

  // One request on the selected DUT, called at a negedge; requests drop 'hold' cycles after done.
  task automatic txn(input string name, input bit u4, input bit rd, input bit wr,
                     input logic [12:0] a, input logic [15:0] d, input int hold,
                     input bit exp_wr, input bit exp_rd, input logic [15:0] exp_data,
                     output int acc);
    int c0, wl, n_wr, n_rd;
    bit seen, dw, dr;
    logic [15:0] dv, rdv;
    c0 = cyc; wl = u4 ? W4 : W2;
    n_wr = 0; n_rd = 0; seen = 0; acc = -1; rdv = '0;
    addr = a; wr_data = d;
    if (u4) begin read4 = rd; write4 = wr; end
    else    begin read  = rd; write  = wr; end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      dw = u4 ? wr_done4 : wr_done;
      dr = u4 ? rd_done4 : rd_done;
      dv = u4 ? rd_data4 : rd_data;
      if (dw) n_wr++;
      if (dr) n_rd++;
      if ((dw || dr) && !seen) begin seen = 1; acc = cyc; rdv = dv; end
      if ((seen && cyc >= acc + hold) || i == 12 || i == 29) begin
        read = 0; write = 0; read4 = 0; write4 = 0;
      end
    end
    chk({name, " wr_done pulses"}, n_wr, {31'b0, exp_wr});
    chk({name, " rd_done pulses"}, n_rd, {31'b0, exp_rd});
    if (exp_wr || exp_rd) chk({name, " done cycle"}, acc, c0 + wl + 2);
    if (exp_rd) begin
      chk({name, " rd_data at done"}, rdv, exp_data);
      chk({name, " rd_data held"}, u4 ? rd_data4 : rd_data, exp_data);
    end
  endtask

  initial begin
    int acc, e1, c0, pred, n;
    logic [15:0] d, x;
    logic [1:0] off;
    bit rd, wr, insel;
    logic [12:0] a;

    led_m = 0; scr_m = 0;
    #2 rst = 0;
    #1;
    chk("reset rd_data", rd_data, 0);
    chk("reset wr_done", wr_done, 0);
    chk("reset rd_done", rd_done, 0);
    chk("reset led", led, 0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);

    // LED write, pin, readback
    txn("led wr", 0, 0, 1, BASE, 16'h000A, 0, 1, 0, 0, acc);
    led_m = 4'hA;
    chk("led port", led, 4'hA);
    txn("led rd", 0, 1, 0, BASE, 0, 0, 0, 1, 16'h000A, acc);

    // Scratch, then an unselected read leaves rd_data alone
    txn("scr wr", 0, 0, 1, BASE + 1, 16'hBEEF, 0, 1, 0, 0, acc);
    scr_m = 16'hBEEF;
    txn("scr rd", 0, 1, 0, BASE + 1, 0, 0, 0, 1, 16'hBEEF, acc);
    txn("unsel rd", 0, 1, 0, 13'h0100, 0, 0, 0, 0, 0, acc);
    chk("rd_data held after unsel", rd_data, 16'hBEEF);
    txn("after unsel rd", 0, 1, 0, BASE, 0, 0, 0, 1, {12'h0, led_m}, acc);

    // read+write together is a write; held request yields one pulse
    txn("rw both", 0, 1, 1, BASE + 1, 16'h1234, 10, 1, 0, 0, acc);
    scr_m = 16'h1234;
    txn("rw readback", 0, 1, 0, BASE + 1, 0, 0, 0, 1, 16'h1234, acc);

`ifdef MMIO_TIMER_EN
    txn("tmr wr", 0, 0, 1, BASE + 2, 16'hFFFE, 0, 1, 0, 0, e1);
    txn("status set", 0, 1, 0, BASE + 3, 0, 0, 0, 1, 16'h0001, acc);
    pred = cyc + W2 + 2;
    x = 16'(32'hFFFE + pred - 1 - e1);
    txn("tmr rd", 0, 1, 0, BASE + 2, 0, 0, 0, 1, x, acc);
    txn("status w1c", 0, 0, 1, BASE + 3, 16'h0001, 0, 1, 0, 0, acc);
    txn("status clr", 0, 1, 0, BASE + 3, 0, 0, 0, 1, 16'h0000, acc);
    // Timer value chosen so it is FFFF exactly at the STATUS write's access edge
    x = 16'(32'hFFFF - (KGAP + W2 + 1));
    txn("tmr wr2", 0, 0, 1, BASE + 2, x, 0, 1, 0, 0, e1);
    wait_until(e1 + KGAP);
    txn("status w1c+ovf", 0, 0, 1, BASE + 3, 16'h0001, 0, 1, 0, 0, acc);
    txn("status sticky", 0, 1, 0, BASE + 3, 0, 0, 0, 1, 16'h0001, acc);
`else
    txn("tmr rd0", 0, 1, 0, BASE + 2, 0, 0, 0, 1, 16'h0000, acc);
    txn("tmr wr", 0, 0, 1, BASE + 2, 16'hFFFE, 0, 1, 0, 0, acc);
    txn("tmr rd1", 0, 1, 0, BASE + 2, 0, 0, 0, 1, 16'h0000, acc);
    txn("status rd", 0, 1, 0, BASE + 3, 0, 0, 0, 1, 16'h0000, acc);
`endif

    // Abort during wait on the 4-wait-state instance
    txn("d4 scr wr", 1, 0, 1, BASE + 1, 16'h5A5A, 0, 1, 0, 0, acc);
    txn("d4 led wr", 1, 0, 1, BASE, 16'h0003, 0, 1, 0, 0, acc);
    txn("d4 led rd", 1, 1, 0, BASE, 0, 0, 0, 1, 16'h0003, acc);
    addr = BASE + 1; read4 = 1;
    @(negedge clk); @(negedge clk);
    read4 = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_done4 || wr_done4) n++;
    end
    chk("abort no done", n, 0);
    chk("abort rd_data kept", rd_data4, 16'h0003);
    txn("d4 after abort", 1, 1, 0, BASE + 1, 0, 0, 0, 1, 16'h5A5A, acc);

    // Random LED/scratch traffic against the register model
    for (int k = 0; k < 24; k++) begin
      d = 16'($urandom);
      rd = 0; wr = 0;
      case ($urandom_range(0, 2))
        0: rd = 1;
        1: wr = 1;
        default: begin rd = 1; wr = 1; end
      endcase
`ifdef MMIO_TIMER_EN
      off = 2'($urandom_range(0, 1));
`else
      off = 2'($urandom_range(0, 3));
`endif
      insel = ($urandom_range(0, 4) != 0);
      a = insel ? (BASE + {11'b0, off}) : (13'h0100 + 13'($urandom_range(0, 255)));
      txn("rand", 0, rd, wr, a, d, 0, insel && wr, insel && !wr, model_rd(off), acc);
      if (insel && wr) begin
        if (off == 2'd0) led_m = d[3:0];
        if (off == 2'd1) scr_m = d;
      end
      chk("rand led port", led, led_m);
    end

    // Asynchronous reset during wait
    txn("pre rst led", 0, 0, 1, BASE, 16'h0006, 0, 1, 0, 0, acc);
    led_m = 4'h6;
    txn("pre rst scr", 0, 0, 1, BASE + 1, 16'hC3C3, 0, 1, 0, 0, acc);
    scr_m = 16'hC3C3;
    txn("pre rst rd", 0, 1, 0, BASE + 1, 0, 0, 0, 1, 16'hC3C3, acc);
    c0 = cyc;
    addr = BASE; wr_data = 16'h0009; write = 1;
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("mid rst rd_data", rd_data, 0);
    chk("mid rst led", led, 0);
    chk("mid rst wr_done", wr_done, 0);
    chk("mid rst rd_done", rd_done, 0);
    write = 0;
    led_m = 0; scr_m = 0;
    @(negedge clk);
    rst = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_done || rd_done) n++;
    end
    chk("no done after rst", n, 0);
    txn("post rst led", 0, 1, 0, BASE, 0, 0, 0, 1, 16'h0000, acc);
    txn("post rst scr", 0, 1, 0, BASE + 1, 0, 0, 0, 1, 16'h0000, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
